seg_display_ctrl: RTL and testbench
===================================

# seg_display_ctrl

Parametrised multiplexed seven-segment display controller for the Basys3 front panel. It replaces the separate clock divider, digit scanner and hex decoder with one block of DIGITS digits. It latches a display value on a load strobe and scans it onto active-low anodes and segments. It can optionally convert the binary value to decimal with a sequential double-dabble engine. It sits between datapath results (e.g. the ALU Y output) and the board pins.

## Interface
- DIGITS, 4: number of digits scanned; value width is 4*DIGITS.
- REFRESH_DIV, 100000: clock cycles per digit slot (1 kHz digit rate at 100 MHz); must be ≥2.
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- value  in  4*DIGITS  binary value to display; digit 0 = value[3:0] in hex mode.
- load  in  1  one-cycle strobe; captures value (and dp, mode).
- mode  in  1  0 = hex, 1 = decimal (only with SEG_BCD_EN; ignored otherwise).
- dp  in  DIGITS  decimal-point enables per digit, captured on load.
- blank  in  DIGITS  per-digit live blank mask, not captured; 1 forces digit dark.
- busy  out  1  high while a decimal conversion is running.
- seg  out  7  {g,f,e,d,c,b,a}, active low.
- dp_n  out  1  decimal point, active low.
- an  out  DIGITS  anode enables, active low, one-hot-low.

## Operation
- Prescaler counts 0..REFRESH_DIV-1. The tick fires on terminal count. On a tick, the digit index advances idx → idx+1, wrapping DIGITS-1 → 0.
- Display register holds DIGITS nibbles plus an overflow flag.
- Hex mode, or block built without SEG_BCD_EN:
  - load copies value into the display register on the same edge.
  - busy stays 0.
- Decimal mode (SEG_BCD_EN, mode=1 at load):
  - FSM IDLE → CONV → IDLE.
  - CONV runs 4*DIGITS shift-add-3 iterations, one per cycle, MSB first.
  - Any 1 shifted out of the top BCD digit sets a sticky overflow.
  - On completion, the BCD result and overflow flag are written to the display register.
  - busy is high for exactly 4*DIGITS cycles, starting the cycle after load.
  - The display keeps the old contents until completion.
- load while busy=1 is ignored. It is not queued.
- Decoder:
  - Nibble 0–F maps to standard hex glyphs; 0 = 7'b1000000, 8 = 7'b0000000, F = 7'b0001110.
  - Overflow forces every digit to minus, 7'b0111111, with dp_n=1.
  - blank[idx]=1 forces seg=7'b1111111 and dp_n=1; the anode is still driven.
- Decimal values are shown without leading-zero suppression.

## Timing
- Reset values: prescaler 0, idx 0, display register 0, overflow 0, FSM IDLE, busy 0.
- Outputs during reset: an all ones, seg 7'b1111111, dp_n 1.
- seg, dp_n and an are registered.
  - The first cycle after reset release drives digit 0, an = ~1.
  - Output reflects the idx/display state of the previous cycle (1-cycle latency).
- Hex load at edge N: new glyph appears on an active digit from edge N+1.
- Decimal load at edge N:
  - busy=1 on cycles N+1 .. N+4*DIGITS.
  - Display is updated at edge N+4*DIGITS, and busy=0 on the next cycle.
- blank and dp changes take effect on the next edge, independent of load.
- Reset mid-conversion aborts it, clears the display register, and returns busy to 0 on the next edge.
- load coinciding with reset: reset wins.

## Configuration
- SEG_BCD_EN defined: double-dabble FSM, overflow flag and the mode input are compiled in.
- SEG_BCD_EN undefined:
  - Hex only; mode is unused.
  - busy is tied 0.
  - The overflow glyph never appears.
  - No conversion registers are instantiated.

## Test plan
- Reset release, REFRESH_DIV=4, DIGITS=4 → an cycles 1110, 1101, 1011, 0111, 1110; each held 4 cycles, wrap observed.
- Hex load value=16'h1A3F → digits 0..3 show seg 0001110, 0110000, 0001000, 1111001.
- SEG_BCD_EN, mode=1, load value=16'd1234:
  - busy high for exactly 16 cycles.
  - Digits then show 4, 3, 2, 1.
  - A second load asserted during busy is ignored.
- SEG_BCD_EN, mode=1, load value=16'd10000 → every active digit shows 7'b0111111.
- blank=4'b0010 and dp=4'b0001 at load → digit 1 dark with its anode low; digit 0 dp_n=0, other digits dp_n=1.
- Reset asserted at cycle 5 of a conversion → busy 0, display all zero glyphs (7'b1000000), idx 0 on the next cycle.

Source files
------------

// File: rtl/seg_display_ctrl.sv
// Multiplexed seven-segment display controller: latches a value and scans it onto active-low pins.
// Define SEG_BCD_EN to add the sequential double-dabble decimal conversion path.
module seg_display_ctrl #(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [4*DIGITS-1:0] value,
    input  logic                load,
    input  logic                mode,
    input  logic [DIGITS-1:0]   dp,
    input  logic [DIGITS-1:0]   blank,
    output logic                busy,
    output logic [6:0]          seg,
    output logic                dp_n,
    output logic [DIGITS-1:0]   an
);

    localparam int unsigned W  = 4 * DIGITS;
    localparam int unsigned PW = $clog2(REFRESH_DIV);
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [PW-1:0]     pre_q;
    logic [IW-1:0]     idx_q;
    logic [W-1:0]      disp_q;
    logic [DIGITS-1:0] dp_q;
    logic              ovf_disp;
    logic              tick;
    logic              accept;
    logic              disp_we;
    logic [W-1:0]      disp_new;

    assign tick = (pre_q == PW'(REFRESH_DIV - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            pre_q <= '0;
            idx_q <= '0;
        end else if (tick) begin
            pre_q <= '0;
            idx_q <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end else begin
            pre_q <= pre_q + PW'(1);
        end
    end

`ifdef SEG_BCD_EN
    localparam int unsigned CW = $clog2(W);

    typedef enum logic {StIdle, StConv} state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  bin_q, bin_d, bcd_q, bcd_d, adj;
    logic [CW-1:0] it_q, it_d;
    logic          ovf_q, ovf_d, ovf_disp_q, conv_done;

    // Add-3 correction on every BCD digit before the shift
    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        it_d      = it_q;
        conv_done = 1'b0;
        case (state_q)
            StIdle: begin
                if (load && mode) begin
                    state_d = StConv;
                    bin_d   = value;
                    bcd_d   = '0;
                    ovf_d   = 1'b0;
                    it_d    = '0;
                end
            end
            StConv: begin
                bcd_d = {adj[W-2:0], bin_q[W-1]};
                bin_d = bin_q << 1;
                ovf_d = ovf_q | adj[W-1];
                it_d  = it_q + CW'(1);
                if (it_q == CW'(W - 1)) begin
                    state_d   = StIdle;
                    conv_done = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            bin_q      <= '0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
            it_q       <= '0;
            ovf_disp_q <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            it_q    <= it_d;
            if (accept && !mode) ovf_disp_q <= 1'b0;
            else if (conv_done) ovf_disp_q <= ovf_d;
        end
    end

    assign busy     = (state_q == StConv);
    assign accept   = load && (state_q == StIdle);
    assign disp_we  = (accept && !mode) || conv_done;
    assign disp_new = conv_done ? bcd_d : value;
    assign ovf_disp = ovf_disp_q;
`else
    logic unused_mode;

    assign unused_mode = mode;
    assign busy        = 1'b0;
    assign accept      = load;
    assign disp_we     = load;
    assign disp_new    = value;
    assign ovf_disp    = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            disp_q <= '0;
            dp_q   <= '0;
        end else begin
            if (disp_we) disp_q <= disp_new;
            if (accept) dp_q <= dp;
        end
    end

    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        case (n)
            4'h0: hex_glyph = 7'b1000000;
            4'h1: hex_glyph = 7'b1111001;
            4'h2: hex_glyph = 7'b0100100;
            4'h3: hex_glyph = 7'b0110000;
            4'h4: hex_glyph = 7'b0011001;
            4'h5: hex_glyph = 7'b0010010;
            4'h6: hex_glyph = 7'b0000010;
            4'h7: hex_glyph = 7'b1111000;
            4'h8: hex_glyph = 7'b0000000;
            4'h9: hex_glyph = 7'b0010000;
            4'hA: hex_glyph = 7'b0001000;
            4'hB: hex_glyph = 7'b0000011;
            4'hC: hex_glyph = 7'b1000110;
            4'hD: hex_glyph = 7'b0100001;
            4'hE: hex_glyph = 7'b0000110;
            default: hex_glyph = 7'b0001110;
        endcase
    endfunction

    logic [3:0] cur_nib;
    logic       cur_blank, cur_dp, dpn_d;
    logic [6:0] seg_d;

    always_comb begin
        cur_nib   = '0;
        cur_blank = 1'b0;
        cur_dp    = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                cur_nib   = disp_q[4*i +: 4];
                cur_blank = blank[i];
                cur_dp    = dp_q[i];
            end
        end
        if (cur_blank) begin
            seg_d = 7'b1111111;
            dpn_d = 1'b1;
        end else if (ovf_disp) begin
            seg_d = 7'b0111111;
            dpn_d = 1'b1;
        end else begin
            seg_d = hex_glyph(cur_nib);
            dpn_d = ~cur_dp;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            an   <= '1;
            seg  <= 7'b1111111;
            dp_n <= 1'b1;
        end else begin
            an   <= ~(DIGITS'(1) << idx_q);
            seg  <= seg_d;
            dp_n <= dpn_d;
        end
    end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Self-checking bench for seg_display_ctrl: directed literal checks plus randomized traffic
// compared every cycle against an arithmetic model of the display.
module tb_seg_display_ctrl;

    localparam int D   = 4;
    localparam int DIV = 4;
    localparam int W   = 4 * D;
`ifdef SEG_BCD_EN
    localparam bit BCD = 1'b1;
`else
    localparam bit BCD = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] value = '0;
    logic         load  = 1'b0;
    logic         mode  = 1'b0;
    logic [D-1:0] dp    = '0;
    logic [D-1:0] blank = '0;
    logic         busy;
    logic [6:0]   seg;
    logic         dp_n;
    logic [D-1:0] an;

    always #5 clock = ~clock;

    seg_display_ctrl #(
        .DIGITS     (D),
        .REFRESH_DIV(DIV)
    ) dut (
        .clock(clock),
        .reset(reset),
        .value(value),
        .load (load),
        .mode (mode),
        .dp   (dp),
        .blank(blank),
        .busy (busy),
        .seg  (seg),
        .dp_n (dp_n),
        .an   (an)
    );

    int checks   = 0;
    int failures = 0;

    logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    // Model: the shown number as an integer, decimal flag, and a countdown for a conversion
    int           cyc, disp_val, conv_left, pend, m_idx, m_nib;
    bit           disp_dec, mvalid = 1'b0;
    logic [D-1:0] dp_m, exp_an;
    logic [6:0]   exp_seg;
    logic         exp_dpn, exp_busy;

    always @(posedge clock) begin
        if (reset) begin
            exp_an    = '1;
            exp_seg   = 7'h7F;
            exp_dpn   = 1'b1;
            cyc       = 0;
            disp_val  = 0;
            disp_dec  = 1'b0;
            dp_m      = '0;
            conv_left = 0;
            pend      = 0;
        end else begin
            m_idx          = (cyc / DIV) % D;
            exp_an         = '1;
            exp_an[m_idx]  = 1'b0;
            if (disp_dec) m_nib = (disp_val / pow10(m_idx)) % 10;
            else m_nib = (disp_val >> (4 * m_idx)) & 15;
            if (blank[m_idx]) begin
                exp_seg = 7'h7F;
                exp_dpn = 1'b1;
            end else if (disp_dec && disp_val >= pow10(D)) begin
                exp_seg = 7'b0111111;
                exp_dpn = 1'b1;
            end else begin
                exp_seg = glyph_tab[m_nib];
                exp_dpn = ~dp_m[m_idx];
            end
            cyc++;
            if (conv_left > 0) begin
                conv_left--;
                if (conv_left == 0) begin
                    disp_val = pend;
                    disp_dec = 1'b1;
                end
            end else if (load) begin
                dp_m = dp;
                if (BCD && mode) begin
                    pend      = int'(value);
                    conv_left = W;
                end else begin
                    disp_val = int'(value);
                    disp_dec = 1'b0;
                end
            end
        end
        exp_busy = (conv_left > 0);
        mvalid   = 1'b1;
    end

    always @(negedge clock) begin
        if (mvalid) begin
            check_val("cyc_an", 32'(an), 32'(exp_an));
            check_val("cyc_seg", 32'(seg), 32'(exp_seg));
            check_val("cyc_dp_n", 32'(dp_n), 32'(exp_dpn));
            check_val("cyc_busy", 32'(busy), 32'(exp_busy));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    logic [D-1:0] an_hist [17];
    logic [6:0]   g [D];
    logic         gd [D];

    task automatic collect_digits();
        for (int d = 0; d < D; d++) begin
            g[d]  = 'x;
            gd[d] = 1'bx;
        end
        for (int k = 0; k < D * DIV; k++) begin
            for (int d = 0; d < D; d++) begin
                if (an == ~(D'(1) << d)) begin
                    g[d]  = seg;
                    gd[d] = dp_n;
                end
            end
            step(1);
        end
    endtask

    initial begin
        int busycnt;
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        step(1);
        for (int k = 0; k < 17; k++) begin
            an_hist[k] = an;
            if (k < 16) step(1);
        end
        check_val("scan_k0", 32'(an_hist[0]), 32'(4'b1110));
        check_val("scan_k3", 32'(an_hist[3]), 32'(4'b1110));
        check_val("scan_k4", 32'(an_hist[4]), 32'(4'b1101));
        check_val("scan_k8", 32'(an_hist[8]), 32'(4'b1011));
        check_val("scan_k12", 32'(an_hist[12]), 32'(4'b0111));
        check_val("scan_k15", 32'(an_hist[15]), 32'(4'b0111));
        check_val("scan_wrap", 32'(an_hist[16]), 32'(4'b1110));
        check_val("rst_glyph", 32'(seg), 32'(7'b1000000));

        value = 16'h1A3F;
        mode  = 1'b0;
        dp    = 4'b0001;
        blank = 4'b0010;
        load  = 1'b1;
        step(1);
        load = 1'b0;
        step(1);
        collect_digits();
        check_val("hex_d0", 32'(g[0]), 32'(7'b0001110));
        check_val("hex_d1_blank", 32'(g[1]), 32'(7'b1111111));
        check_val("hex_d2", 32'(g[2]), 32'(7'b0001000));
        check_val("hex_d3", 32'(g[3]), 32'(7'b1111001));
        check_val("dp_d0", 32'(gd[0]), 32'(1'b0));
        check_val("dp_d1", 32'(gd[1]), 32'(1'b1));
        check_val("dp_d2", 32'(gd[2]), 32'(1'b1));
        check_val("dp_d3", 32'(gd[3]), 32'(1'b1));
        blank = '0;
        dp    = '0;

`ifdef SEG_BCD_EN
        value = 16'd1234;
        mode  = 1'b1;
        load  = 1'b1;
        step(1);
        load    = 1'b0;
        busycnt = 0;
        for (int k = 0; k < 24; k++) begin
            if (busy) busycnt++;
            if (k == 3) begin
                load  = 1'b1;
                value = 16'h0042;
                mode  = 1'b0;
            end else begin
                load = 1'b0;
            end
            step(1);
        end
        check_val("bcd_busy_len", 32'(busycnt), 32'd16);
        collect_digits();
        check_val("bcd_d0", 32'(g[0]), 32'(7'b0011001));
        check_val("bcd_d1", 32'(g[1]), 32'(7'b0110000));
        check_val("bcd_d2", 32'(g[2]), 32'(7'b0100100));
        check_val("bcd_d3", 32'(g[3]), 32'(7'b1111001));

        value = 16'd10000;
        mode  = 1'b1;
        load  = 1'b1;
        step(1);
        load = 1'b0;
        step(20);
        collect_digits();
        for (int d = 0; d < D; d++) begin
            check_val("ovf_seg", 32'(g[d]), 32'(7'b0111111));
            check_val("ovf_dp_n", 32'(gd[d]), 32'(1'b1));
        end

        value = 16'd1234;
        mode  = 1'b1;
        load  = 1'b1;
        step(1);
        load = 1'b0;
        step(4);
        check_val("abort_busy_before", 32'(busy), 32'(1'b1));
        reset = 1'b1;
        step(1);
        check_val("abort_busy", 32'(busy), 32'(1'b0));
        check_val("abort_an", 32'(an), 32'(4'b1111));
        reset = 1'b0;
        step(1);
        check_val("abort_idx0", 32'(an), 32'(4'b1110));
        check_val("abort_zero", 32'(seg), 32'(7'b1000000));
`endif

        for (int i = 0; i < 3000; i++) begin
            load  = ($urandom_range(0, 7) == 0);
            mode  = 1'($urandom_range(0, 1));
            value = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'($urandom_range(0, 9999));
            dp    = 4'($urandom);
            blank = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0000;
            reset = ($urandom_range(0, 299) == 0);
            step(1);
        end
        reset = 1'b0;
        load  = 1'b0;
        step(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
